poly_add_sub_seq: RTL and testbench
===================================

// Module: poly_add_sub_seq
// PURPOSE
//  Sequences a whole-polynomial modular add/sub, C[i] = (A[i] +/- B[i]) mod 3329, for i = 0..N_COEFFS-1.
//  Streams coefficients from two sync-read coefficient memories through one internal mod_uni_add_sub
//  instance (2-cycle latency) and writes the results to a third memory. Sits between the poly-arith
//  top-level command decoder and the coefficient RAMs. Fixed streaming schedule, one coefficient per cycle, no stalls.
// PARAMETERS
//  N_COEFFS  256                 coefficients per polynomial; must be >= 1
//  ADDR_W    $clog2(N_COEFFS)    coefficient address width; must be >= 1
// PORTS
//  clk        in   1       clock
//  rst        in   1       synchronous active-high reset
//  start_i    in   1       start request; sampled only in IDLE
//  is_sub_i   in   1       1 = C = A-B, 0 = C = A+B; latched when start is accepted
//  busy_o     out  1       high whenever state != IDLE
//  done_o     out  1       one-cycle pulse when the last coefficient has been written
//  rd_en_o    out  1       read strobe, shared by the A and B memories
//  rd_addr_o  out  ADDR_W  read address, shared by the A and B memories
//  a_data_i   in   12      A memory read data, valid 1 cycle after rd_en_o
//  b_data_i   in   12      B memory read data, valid 1 cycle after rd_en_o
//  wr_en_o    out  1       C memory write strobe
//  wr_addr_o  out  ADDR_W  C memory write address
//  wr_data_o  out  12      C memory write data (coeff_t)
// BEHAVIOUR
//  - Reset: state=IDLE. busy_o, done_o, rd_en_o, wr_en_o = 0. rd_addr_o, wr_addr_o = 0. Latched op = add.
//    The inner unit is reset from the same rst, so its in-flight valids are flushed.
//  - FSM states: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//  - IDLE: start_i=1 latches is_sub_i, clears the read and write counters, and moves to RUN.
//  - RUN (exactly N_COEFFS cycles): rd_en_o=1, rd_addr_o = read counter (0..N_COEFFS-1), counter +1 per cycle.
//    After issuing address N_COEFFS-1, move to DRAIN.
//  - DRAIN (exactly 3 cycles, down-counter): rd_en_o=0; waits for in-flight results, then moves to DONE.
//  - DONE (1 cycle): done_o=1, then IDLE.
//  - Pipeline: rd_en_o registered 1 cycle -> valid_i of the inner unit, with a_data_i/b_data_i as op1/op2
//    and the latched is_sub as is_sub_i.
//  - Write port: wr_en_o = inner valid_o; wr_data_o = inner result_o (combinational pass-through,
//    no extra register).
//  - Write address: wr_addr_o = write counter. Counter clears on start acceptance, increments after
//    each wr_en_o cycle, and wraps to 0 after N_COEFFS-1.
//  - Timing, start sampled at edge 0 (cycle 1 = first RUN cycle):
//      read addr i in cycle i+1; write addr i in cycle i+4;
//      last write in cycle N_COEFFS+3; done_o in cycle N_COEFFS+4.
//  - Every index 0..N_COEFFS-1 is written exactly once, in ascending order, with no gaps between writes.
//  - Arithmetic: inputs are assumed < 3329; the result is always in 0..3328.
//    Sub with B=0 yields A; sub with A<B wraps (A-B+3329).
//  - start_i while state != IDLE (RUN, DRAIN, DONE) is ignored and not queued.
//    is_sub_i changes mid-run have no effect.
//  - Back-to-back: the earliest next start is accepted in the cycle after done_o (state IDLE).
//  - rst mid-operation: FSM -> IDLE on the next edge; no further wr_en_o; done_o is not asserted.
//    C memory contents are partially updated; this is the caller's responsibility.
// TESTING
//  1. Add: A[i]=i, B[i]=3328 (N=256), start -> C[0]=3328, C[1]=0, C[255]=254.
//     done_o exactly at cycle 260; 256 writes.
//  2. Sub wrap: A[i]=0, B[i]=1, is_sub=1 -> every C[i]=3328.
//     Also A=5, B=0 -> C=5 (Q-0 path).
//  3. Cycle accuracy: N_COEFFS=4 -> rd_en_o high in cycles 1-4; wr_en_o in cycles 4-7 at addrs 0..3;
//     done_o in cycle 8; busy_o high in cycles 1-8.
//  4. Start while busy: pulse start_i in cycles 10 and N+4 (with is_sub toggled) -> no restart,
//     op unchanged, a single done_o.
//  5. Back-to-back: start in the cycle after done_o, with the opposite op ->
//     second run correct, write address restarts at 0.
//  6. Reset mid-run: rst in cycle 100 of a 256 run -> wr_en_o=0 from cycle 101, busy_o=0, no done_o.
//     A following start completes normally.

Source files
------------

// File: rtl/poly_add_sub_seq.sv
// Whole-polynomial modular add/sub sequencer: streams A/B coefficients through a
// 2-cycle mod-3329 add/sub unit and writes C in ascending order, one per cycle.

module mod_uni_add_sub #(
  parameter logic [11:0] Q = 12'd3329
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [11:0] op1_i,
  input  logic [11:0] op2_i,
  input  logic        is_sub_i,
  output logic        valid_o,
  output logic [11:0] result_o
);
  logic [12:0] sum_q, sum_d;
  logic [11:0] res_q, res_d;
  logic        v1_q, v2_q;

  // Subtraction is done as A + (Q - B) so both ops share one conditional -Q stage.
  always_comb begin
    sum_d = {1'b0, op1_i} + (is_sub_i ? {1'b0, Q - op2_i} : {1'b0, op2_i});
    res_d = (sum_q >= {1'b0, Q}) ? 12'(sum_q - {1'b0, Q}) : sum_q[11:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      sum_q <= '0;
      res_q <= '0;
    end else begin
      v1_q  <= valid_i;
      v2_q  <= v1_q;
      sum_q <= sum_d;
      res_q <= res_d;
    end
  end

  assign valid_o  = v2_q;
  assign result_o = res_q;
endmodule

module poly_add_sub_seq #(
  parameter int N_COEFFS = 256,
  parameter int ADDR_W   = $clog2(N_COEFFS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              is_sub_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [11:0]       a_data_i,
  input  logic [11:0]       b_data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [11:0]       wr_data_o
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_COEFFS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [1:0]        drain_q, drain_d;
  logic              is_sub_q, is_sub_d;
  logic              rd_vld_q;
  logic              au_valid;
  logic [11:0]       au_result;

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    drain_d  = drain_q;
    is_sub_d = is_sub_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          is_sub_d = is_sub_i;
          rd_cnt_d = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (rd_cnt_q == LAST_ADDR) begin
          rd_cnt_d = '0;
          drain_d  = 2'd2;
          state_d  = S_DRAIN;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == 2'd0) state_d = S_DONE;
        else                 drain_d = drain_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_IDLE && start_i) begin
      wr_cnt_d = '0;
    end else if (au_valid) begin
      wr_cnt_d = (wr_cnt_q == LAST_ADDR) ? '0 : wr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      drain_q  <= '0;
      is_sub_q <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      drain_q  <= drain_d;
      is_sub_q <= is_sub_d;
      rd_vld_q <= rd_en_o;
    end
  end

  mod_uni_add_sub u_addsub (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (rd_vld_q),
    .op1_i    (a_data_i),
    .op2_i    (b_data_i),
    .is_sub_i (is_sub_q),
    .valid_o  (au_valid),
    .result_o (au_result)
  );

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign rd_en_o   = (state_q == S_RUN);
  assign rd_addr_o = rd_cnt_q;
  assign wr_en_o   = au_valid;
  assign wr_addr_o = wr_cnt_q;
  assign wr_data_o = au_result;
endmodule

// File: tb/tb_poly_add_sub_seq.sv
// Directed bench for poly_add_sub_seq: a 256-coefficient instance for function/control
// cases and a 4-coefficient instance for cycle-exact strobe timing.

module tb_poly_add_sub_seq;
  localparam int N  = 256;
  localparam int N4 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, is_sub, busy, done, rd_en, wr_en;
  logic [7:0]  rd_addr, wr_addr;
  logic [11:0] a_data, b_data, wr_data;

  logic        start4, is_sub4, busy4, done4, rd_en4, wr_en4;
  logic [1:0]  rd_addr4, wr_addr4;
  logic [11:0] a_data4, b_data4, wr_data4;

  int A[N], B[N], C[N];
  int A4[N4], B4[N4], C4[N4];

  poly_add_sub_seq #(.N_COEFFS(N), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start_i(start), .is_sub_i(is_sub), .busy_o(busy), .done_o(done),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .a_data_i(a_data), .b_data_i(b_data),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data)
  );

  poly_add_sub_seq #(.N_COEFFS(N4), .ADDR_W(2)) dut4 (
    .clk(clk), .rst(rst), .start_i(start4), .is_sub_i(is_sub4), .busy_o(busy4), .done_o(done4),
    .rd_en_o(rd_en4), .rd_addr_o(rd_addr4), .a_data_i(a_data4), .b_data_i(b_data4),
    .wr_en_o(wr_en4), .wr_addr_o(wr_addr4), .wr_data_o(wr_data4)
  );

  // Sync-read coefficient memories
  always @(posedge clk) begin
    if (rd_en) begin
      a_data <= 12'(A[rd_addr]);
      b_data <= 12'(B[rd_addr]);
    end
    if (rd_en4) begin
      a_data4 <= 12'(A4[rd_addr4]);
      b_data4 <= 12'(B4[rd_addr4]);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int n_wr, done_cyc, done_cnt, first_wr, last_wr, order_err, busy_lo, late_wr, busy_after_rst;

  // Cycle c is the interval after edge c-1; start is sampled at edge 0.
  task automatic run_big(input logic sub, input int cycles, input int rst_cyc,
                         input int pa, input int pb);
    n_wr = 0; done_cyc = -1; done_cnt = 0; first_wr = -1; last_wr = -1;
    order_err = 0; busy_lo = 0; late_wr = 0; busy_after_rst = -1;
    @(negedge clk);
    start  = 1'b1;
    is_sub = sub;
    @(posedge clk);
    #1;
    start  = 1'b0;
    is_sub = ~sub;
    for (int c = 1; c <= cycles; c++) begin
      @(negedge clk);
      if (wr_en) begin
        C[wr_addr] = int'(wr_data);
        if (int'(wr_addr) != n_wr % N) order_err++;
        if (c != n_wr + 4) order_err++;
        if (first_wr < 0) first_wr = c;
        last_wr = c;
        if (rst_cyc > 0 && c > rst_cyc) late_wr++;
        n_wr++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (rst_cyc == 0 && c <= N + 4 && !busy) busy_lo++;
      if (rst_cyc > 0 && c == rst_cyc + 1) busy_after_rst = int'(busy);
      start = (c == pa || c == pb);
      rst   = (c == rst_cyc);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic fill_add_pattern();
    for (int i = 0; i < N; i++) begin
      A[i] = i;
      B[i] = 3328;
      C[i] = -1;
    end
  endtask

  logic [10:0] rd_m, wr_m, done_m, busy_m;
  logic [7:0]  ra_seq, wa_seq;
  int          bad;

  initial begin
    rst = 1'b1; start = 1'b0; is_sub = 1'b0; start4 = 1'b0; is_sub4 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_addr", wr_addr, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // N=4 cycle-exact strobes: (3328+1)=0, (3000+400)=71, (100+3328)=99, 7+7=14
    A4 = '{3328, 3000, 100, 7};
    B4 = '{1, 400, 3328, 7};
    C4 = '{-1, -1, -1, -1};
    rd_m = '0; wr_m = '0; done_m = '0; busy_m = '0; ra_seq = '0; wa_seq = '0;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      rd_m[c] = rd_en4; wr_m[c] = wr_en4; done_m[c] = done4; busy_m[c] = busy4;
      if (rd_en4) ra_seq = (ra_seq << 2) | 8'(rd_addr4);
      if (wr_en4) begin
        wa_seq = (wa_seq << 2) | 8'(wr_addr4);
        C4[wr_addr4] = int'(wr_data4);
      end
    end
    check("n4_rd_en_cycles", int'(rd_m), 'h01E);
    check("n4_wr_en_cycles", int'(wr_m), 'h0F0);
    check("n4_done_cycle", int'(done_m), 'h100);
    check("n4_busy_cycles", int'(busy_m), 'h1FE);
    check("n4_rd_addr_seq", int'(ra_seq), 'h1B);
    check("n4_wr_addr_seq", int'(wa_seq), 'h1B);
    check("n4_c0", C4[0], 0);
    check("n4_c1", C4[1], 71);
    check("n4_c2", C4[2], 99);
    check("n4_c3", C4[3], 14);

    // Add: C[i] = (i + 3328) mod 3329
    fill_add_pattern();
    run_big(1'b0, N + 10, 0, 0, 0);
    check("add_c0", C[0], 3328);
    check("add_c1", C[1], 0);
    check("add_c255", C[255], 254);
    check("add_writes", n_wr, 256);
    check("add_done_cycle", done_cyc, 260);
    check("add_done_count", done_cnt, 1);
    check("add_first_wr", first_wr, 4);
    check("add_last_wr", last_wr, 259);
    check("add_order", order_err, 0);
    check("add_busy_gaps", busy_lo, 0);

    // Sub wrap plus edge operands
    for (int i = 0; i < N; i++) begin
      A[i] = 0; B[i] = 1; C[i] = -1;
    end
    A[7] = 5;    B[7] = 0;
    A[8] = 3328; B[8] = 3328;
    A[9] = 100;  B[9] = 3328;
    run_big(1'b1, N + 10, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < N; i++)
      if ((i < 7 || i > 9) && C[i] != 3328) bad++;
    check("sub_wrap_all", bad, 0);
    check("sub_b_zero", C[7], 5);
    check("sub_equal", C[8], 0);
    check("sub_a_lt_b", C[9], 101);
    check("sub_writes", n_wr, 256);
    check("sub_done_cycle", done_cyc, 260);

    // Start pulses while busy (RUN and DONE) with opposite op
    fill_add_pattern();
    run_big(1'b0, N + 10, 0, 10, N + 4);
    check("busy_start_c0", C[0], 3328);
    check("busy_start_c200", C[200], 199);
    check("busy_start_done_count", done_cnt, 1);
    check("busy_start_done_cycle", done_cyc, 260);
    check("busy_start_writes", n_wr, 256);

    // Back-to-back: add then sub started in the cycle after done
    fill_add_pattern();
    run_big(1'b0, N + 4, 0, 0, 0);
    check("b2b_first_done", done_cyc, 260);
    for (int i = 0; i < N; i++) C[i] = -1;
    run_big(1'b1, N + 10, 0, 0, 0);
    check("b2b_sub_c0", C[0], 1);
    check("b2b_sub_c255", C[255], 256);
    check("b2b_first_wr", first_wr, 4);
    check("b2b_order", order_err, 0);
    check("b2b_writes", n_wr, 256);
    check("b2b_done_cycle", done_cyc, 260);

    // Reset in cycle 100, then a normal run
    fill_add_pattern();
    run_big(1'b0, 120, 100, 0, 0);
    check("rst_mid_writes", n_wr, 97);
    check("rst_mid_late_wr", late_wr, 0);
    check("rst_mid_done", done_cnt, 0);
    check("rst_mid_busy", busy_after_rst, 0);
    fill_add_pattern();
    run_big(1'b0, N + 10, 0, 0, 0);
    check("after_rst_c255", C[255], 254);
    check("after_rst_done_cycle", done_cyc, 260);
    check("after_rst_writes", n_wr, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
